// File: rtl/date_set_ctrl.sv
// Date-setting front end: debounces the three watch buttons, walks the
// field-select FSM and issues one-cycle inc/dec strobes with hold-to-repeat.
//
//  state  | meaning
//  -------+-----------------------------------------------
//  NORMAL | date runs, no strobes, blink off
//  SET_Y  | up/down adjust year
//  SET_MO | up/down adjust month
//  SET_D  | up/down adjust day
module date_set_ctrl #(
    parameter int DEB_CYC    = 20,
    parameter int RPT_DELAY  = 500,
    parameter int RPT_PERIOD = 100,
    parameter int TIMEOUT    = 10000,
    parameter int BLINK_HALF = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       inc_y,
    output logic       inc_mo,
    output logic       inc_d,
    output logic       dec_y,
    output logic       dec_mo,
    output logic       dec_d,
    output logic       set_mode,
    output logic [1:0] sel,
    output logic       blink
);

    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        SET_Y  = 2'd1,
        SET_MO = 2'd2,
        SET_D  = 2'd3
    } state_t;

    // bit 0 mode, bit 1 up, bit 2 down
    logic [2:0]    sync1, sync2, deb, deb_q;
    logic [DW-1:0] deb_cnt [3];
    logic [2:0]    press;

    state_t        state, state_nx;
    logic [TW-1:0] to_cnt;
    logic          rpt_act, rpt_dn, rpt_first;
    logic [RW-1:0] rpt_cnt, rpt_lim;
    logic [BW-1:0] blink_cnt;
    logic [5:0]    strb, strb_nx;

    logic in_set, any_press, up_l, dn_l;
    logic fire_up1, fire_dn1, rpt_hold_ok, fire_rpt, fire, fire_dn, st_chg;

    // Synchronize raw buttons and accept a new level only after DEB_CYC equal samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= {btn_down, btn_up, btn_mode};
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] >= DW'(DEB_CYC - 1)) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign press     = deb & ~deb_q;
    assign any_press = |press;
    assign up_l      = deb[1];
    assign dn_l      = deb[2];
    assign in_set    = (state != NORMAL);

    // Next state, strobe decisions and registered strobe values.
    always_comb begin
        state_nx    = state;
        strb_nx     = '0;
        fire_up1    = in_set && press[1] && !dn_l && !press[0];
        fire_dn1    = in_set && press[2] && !up_l && !press[0];
        rpt_hold_ok = rpt_act && !press[0] &&
                      (rpt_dn ? (dn_l && !up_l) : (up_l && !dn_l));
        rpt_lim     = rpt_first ? RW'(RPT_DELAY - 1) : RW'(RPT_PERIOD - 1);
        fire_rpt    = in_set && rpt_hold_ok && (rpt_cnt >= rpt_lim);
        fire        = fire_up1 || fire_dn1 || fire_rpt;
        fire_dn     = fire_dn1 || (fire_rpt && rpt_dn);

        if (press[0])
            state_nx = state_t'(state + 2'd1);
        else if (in_set && !any_press && !fire && to_cnt >= TW'(TIMEOUT - 1))
            state_nx = NORMAL;

        case (state)
            SET_Y:  begin strb_nx[0] = fire && !fire_dn; strb_nx[3] = fire && fire_dn; end
            SET_MO: begin strb_nx[1] = fire && !fire_dn; strb_nx[4] = fire && fire_dn; end
            SET_D:  begin strb_nx[2] = fire && !fire_dn; strb_nx[5] = fire && fire_dn; end
            default: strb_nx = '0;
        endcase
    end

    assign st_chg = (state_nx != state);

    // State register and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= NORMAL;
            strb  <= '0;
        end else begin
            state <= state_nx;
            strb  <= strb_nx;
        end
    end

    // Idle timer: any press or strobe restarts it, as does every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else if (st_chg || any_press || fire || !in_set)
            to_cnt <= '0;
        else if (to_cnt < TW'(TIMEOUT))
            to_cnt <= to_cnt + 1'b1;
    end

    // Hold-to-repeat: armed by a first strobe, dropped on release, chord or mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_act   <= 1'b0;
            rpt_dn    <= 1'b0;
            rpt_first <= 1'b0;
            rpt_cnt   <= '0;
        end else if (st_chg) begin
            rpt_act   <= 1'b0;
            rpt_first <= 1'b0;
            rpt_cnt   <= '0;
        end else if (fire_up1 || fire_dn1) begin
            rpt_act   <= 1'b1;
            rpt_dn    <= fire_dn1;
            rpt_first <= 1'b1;
            rpt_cnt   <= '0;
        end else if (!rpt_hold_ok) begin
            rpt_act   <= 1'b0;
            rpt_first <= 1'b0;
            rpt_cnt   <= '0;
        end else if (fire_rpt) begin
            rpt_first <= 1'b0;
            rpt_cnt   <= '0;
        end else if (rpt_cnt < RW'(RPT_MAX)) begin
            rpt_cnt   <= rpt_cnt + 1'b1;
        end
    end

    // Blink restarts high on entry to any set state and is held low in NORMAL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (st_chg && state_nx != NORMAL) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (state_nx == NORMAL) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt >= BW'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign {dec_d, dec_mo, dec_y, inc_d, inc_mo, inc_y} = strb;
    assign set_mode = in_set;
    assign sel      = state;

endmodule

// File: tb/tb_date_set_ctrl.sv
// Bench for date_set_ctrl: clean button holds are turned into expected strobe
// times by arithmetic, queued, and matched by a free-running monitor.
module tb_date_set_ctrl;

    localparam int DEB = 20;
    localparam int RD  = 500;
    localparam int RP  = 100;
    localparam int TO  = 10000;
    localparam int BH  = 250;

    logic clk = 1'b0;
    logic rst, btn_mode, btn_up, btn_down;
    logic inc_y, inc_mo, inc_d, dec_y, dec_mo, dec_d, set_mode, blink;
    logic [1:0] sel;

    date_set_ctrl dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .inc_y(inc_y), .inc_mo(inc_mo), .inc_d(inc_d),
        .dec_y(dec_y), .dec_mo(dec_mo), .dec_d(dec_d),
        .set_mode(set_mode), .sel(sel), .blink(blink)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int at; int id; } exp_t;
    exp_t  sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    m_sel = 0;
    string names[6] = '{"inc_y", "inc_mo", "inc_d", "dec_y", "dec_mo", "dec_d"};

    task automatic check(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [5:0] s;
        int id;
        s  = {dec_d, dec_mo, dec_y, inc_d, inc_mo, inc_y};
        id = 0;
        if (rst) begin
            if (sb.size() > 0 && sb[0].at < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL missed_strobe: got none expected %s at cycle %0d (now %0d)",
                         names[sb[0].id], sb[0].at, cyc);
                void'(sb.pop_front());
            end
            if (s != 6'd0) begin
                n_checks++;
                for (int k = 0; k < 6; k++) if (s[k]) id = k;
                if ($countones(s) != 1) begin
                    n_errors++;
                    $display("FAIL one_hot_strobe: got %b expected one bit at cycle %0d", s, cyc);
                end else if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_strobe: got %s expected none at cycle %0d", names[id], cyc);
                end else begin
                    if (sb[0].at != cyc || sb[0].id != id) begin
                        n_errors++;
                        $display("FAIL strobe_match: got %s at %0d expected %s at %0d",
                                 names[id], cyc, names[sb[0].id], sb[0].at);
                    end
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick(1);
    endtask

    task automatic push(int at, int id);
        exp_t e;
        e.at = at;
        e.id = id;
        sb.push_back(e);
    endtask

    // Raw high sampled on edges n..n+len-1: press acted on at n+2+DEB, strobe seen then,
    // repeats at +RD, +RD+RP, ... while offset stays inside the hold.
    task automatic push_hold(int is_dn, int n, int len);
        int s, id;
        if (m_sel == 0) return;
        s  = n + 2 + DEB;
        id = (is_dn != 0 ? 3 : 0) + m_sel - 1;
        push(s, id);
        for (int off = RD; off <= len - 1; off += RP) push(s + off, id);
    endtask

    task automatic hold(int is_dn, int len, int gap);
        int n;
        n = cyc + 1;
        push_hold(is_dn, n, len);
        if (is_dn != 0) btn_down = 1'b1; else btn_up = 1'b1;
        tick(len);
        btn_down = 1'b0;
        btn_up   = 1'b0;
        tick(gap);
    endtask

    task automatic mode_pulse(output int e);
        int n;
        n = cyc + 1;
        e = n + 2 + DEB;
        btn_mode = 1'b1;
        tick(40);
        btn_mode = 1'b0;
        tick(30);
        m_sel = (m_sel + 1) % 4;
        check("sel_after_mode", sel, m_sel);
        check("set_mode_after_mode", set_mode, (m_sel != 0) ? 1 : 0);
    endtask

    task automatic goto_sel(int t);
        int e;
        while (m_sel != t) mode_pulse(e);
    endtask

    initial begin
        int e, n, s, len, r, act;
        rst = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        #2;
        check("reset_sel", sel, 0);
        check("reset_set_mode", set_mode, 0);
        check("reset_blink", blink, 0);
        check("reset_strobes", {dec_d, dec_mo, dec_y, inc_d, inc_mo, inc_y}, 0);
        tick(3);
        rst = 1'b1;
        tick(5);

        // mode walk with blink phase checks in SET_Y
        mode_pulse(e);
        check("blink_entry", blink, 1);
        wait_until(e + BH + 10);
        check("blink_half", blink, 0);
        wait_until(e + 2 * BH + 10);
        check("blink_full", blink, 1);
        mode_pulse(e);
        check("blink_entry_mo", blink, 1);
        mode_pulse(e);
        mode_pulse(e);
        check("blink_normal", blink, 0);

        // single press, long hold with repeat
        goto_sel(2);
        hold(0, 40, 40);
        goto_sel(1);
        hold(1, 800, 40);

        // chord: nothing until a fresh solo press
        goto_sel(3);
        btn_up = 1'b1; btn_down = 1'b1;
        tick(100);
        btn_down = 1'b0;
        tick(600);
        btn_up = 1'b0;
        tick(40);
        check("sel_after_chord", sel, 3);
        hold(0, 40, 40);

        // mode press while up held: first strobe only, no repeat in the new field
        goto_sel(1);
        n = cyc + 1;
        push(n + 2 + DEB, 0);
        btn_up = 1'b1;
        tick(100);
        btn_mode = 1'b1;
        tick(40);
        btn_mode = 1'b0;
        m_sel = 2;
        tick(600);
        btn_up = 1'b0;
        tick(40);
        check("sel_mode_during_hold", sel, 2);

        // mode and up pressed in the same cycle: mode wins
        btn_mode = 1'b1; btn_up = 1'b1;
        tick(40);
        btn_mode = 1'b0; btn_up = 1'b0;
        m_sel = 3;
        tick(40);
        check("sel_mode_and_up", sel, 3);

        // randomized holds and mode presses
        for (int it = 0; it < 20; it++) begin
            act = $urandom_range(0, 3);
            if (act == 0) begin
                mode_pulse(e);
            end else begin
                len = $urandom_range(30, 750);
                r = (len + 1000 - RD) % RP;
                if (r < 8 || r > 92) len += 15;
                hold((act == 3) ? 1 : 0, len, $urandom_range(30, 150));
            end
        end

        // idle timeout boundary, then sub-debounce glitches
        goto_sel(0);
        mode_pulse(e);
        wait_until(e + TO - 1);
        check("timeout_before", sel, 1);
        tick(1);
        check("timeout_at", sel, 0);
        m_sel = 0;
        mode_pulse(e);
        repeat (6) begin
            btn_up = 1'b1;
            tick(5);
            btn_up = 1'b0;
            tick(5);
        end
        tick(50);
        check("sel_after_glitch", sel, 1);

        // asynchronous reset in the middle of a repeat
        n = cyc + 1;
        s = n + 2 + DEB;
        push(s, 0);
        push(s + RD, 0);
        btn_up = 1'b1;
        wait_until(s + RD + 50);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_sel", sel, 0);
        check("async_rst_set_mode", set_mode, 0);
        check("async_rst_blink", blink, 0);
        check("async_rst_strobes", {dec_d, dec_mo, dec_y, inc_d, inc_mo, inc_y}, 0);
        check("queue_at_reset", sb.size(), 0);
        btn_up = 1'b0;
        tick(5);
        rst = 1'b1;
        m_sel = 0;
        tick(1);
        check("sel_after_reset", sel, 0);
        tick(700);
        check("sel_quiet_after_reset", sel, 0);

        tick(50);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
